rfid_poll_scheduler: RTL and testbench

- Sequences the RC522 reader controller for the pet's card-interaction logic.
- Issues periodic read requests (`start` pulses) to the reader and supervises each transaction with a timeout.
- Tracks card presence, filtering missed reads with a miss counter, and emits one-cycle `new_card` / `card_removed` events plus a stable UID for game logic.

---
 rtl/rfid_poll_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_rfid_poll_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rfid_poll_scheduler.sv
// rfid_poll_scheduler: periodically polls the RC522 reader controller,
// supervises each transaction with a timeout and turns the raw read results
// into a debounced card-present state with one-cycle appear/remove events.
module rfid_poll_scheduler #(
  parameter int POLL_PERIOD = 5000000,
  parameter int TIMEOUT     = 1000000,
  parameter int MISS_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        rc_start,
  input  logic        rc_done,
  input  logic [31:0] rc_uid,
  output logic [31:0] card_uid,
  output logic        card_valid,
  output logic        new_card,
  output logic        card_removed,
  output logic        timeout_err,
  output logic        busy
);

  localparam int PER_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD + 1) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  // Last count values; comparing against "limit - 1" keeps every compare
  // inside the counter width.
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(POLL_PERIOD - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);
  localparam logic [MISS_W-1:0] MISS_PRE  = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    WAIT_DONE   = 3'd2,
    EVAL        = 3'd3,
    WAIT_PERIOD = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [PER_W-1:0]  per_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic [31:0]       cap_uid;
  logic              hit;
  logic              tmo_flag;
  logic              tmo_expire;

  // The reader is declared hung only when done did not arrive on the last
  // allowed cycle; done on that same cycle still counts as a good read.
  assign tmo_expire = (state == WAIT_DONE) && !rc_done && (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the outputs that follow directly from the state.
  always_comb begin
    state_next = state;
    rc_start   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = START;
        end
      end
      START: begin
        rc_start   = 1'b1;
        busy       = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (rc_done || (tmo_cnt == TMO_LAST)) begin
          state_next = EVAL;
        end
      end
      EVAL: begin
        busy       = 1'b1;
        state_next = enable ? WAIT_PERIOD : IDLE;
      end
      WAIT_PERIOD: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (per_cnt == PER_LAST) begin
          state_next = START;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Transaction timeout counter: cleared on START, counts WAIT_DONE cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == START) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_DONE) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Poll period counter: restarts after every EVAL and while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (state == WAIT_PERIOD) begin
      if (per_cnt != PER_LAST) begin
        per_cnt <= per_cnt + PER_W'(1);
      end else begin
        per_cnt <= '0;
      end
    end else begin
      per_cnt <= '0;
    end
  end

  // Capture the result of the current transaction for evaluation in EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_uid  <= '0;
      hit      <= 1'b0;
      tmo_flag <= 1'b0;
    end else if (state == START) begin
      hit      <= 1'b0;
      tmo_flag <= 1'b0;
    end else if (state == WAIT_DONE) begin
      if (rc_done) begin
        cap_uid <= rc_uid;
        hit     <= (rc_uid != 32'h0);
      end else if (tmo_expire) begin
        hit      <= 1'b0;
        tmo_flag <= 1'b1;
      end
    end
  end

  // Card presence tracking and one-cycle event pulses, updated leaving EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      card_uid     <= '0;
      card_valid   <= 1'b0;
      new_card     <= 1'b0;
      card_removed <= 1'b0;
      timeout_err  <= 1'b0;
      miss_cnt     <= '0;
    end else begin
      new_card     <= 1'b0;
      card_removed <= 1'b0;
      timeout_err  <= 1'b0;
      if (state == EVAL) begin
        timeout_err <= tmo_flag;
        if (hit) begin
          miss_cnt <= '0;
          if (!card_valid || (cap_uid != card_uid)) begin
            card_uid   <= cap_uid;
            card_valid <= 1'b1;
            new_card   <= 1'b1;
          end
        end else begin
          if (miss_cnt != MISS_MAX) begin
            miss_cnt <= miss_cnt + MISS_W'(1);
          end
          if (card_valid && (miss_cnt == MISS_PRE)) begin
            card_valid   <= 1'b0;
            card_uid     <= '0;
            card_removed <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rfid_poll_scheduler.sv
// tb_rfid_poll_scheduler: directed bench acting as the RC522 reader
// controller; expected values are hand-derived from the poll timing.
module tb_rfid_poll_scheduler;

  localparam int POLL_PERIOD = 20;
  localparam int TIMEOUT     = 50;
  localparam int MISS_LIMIT  = 3;
  // rc_done is raised in the DONE_DLY-th cycle after the rc_start cycle.
  localparam int DONE_DLY    = 11;
  localparam int SPACING     = DONE_DLY + 1 + POLL_PERIOD + 1;
  localparam int TMO_SPACING = TIMEOUT + 1 + POLL_PERIOD + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rc_start;
  logic        rc_done;
  logic [31:0] rc_uid;
  logic [31:0] card_uid;
  logic        card_valid;
  logic        new_card;
  logic        card_removed;
  logic        timeout_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int   s_prev;
  int   s_cur;
  logic nc;
  logic rm;
  logic to;
  logic seen;

  rfid_poll_scheduler #(
    .POLL_PERIOD(POLL_PERIOD),
    .TIMEOUT    (TIMEOUT),
    .MISS_LIMIT (MISS_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rc_start    (rc_start),
    .rc_done     (rc_done),
    .rc_uid      (rc_uid),
    .card_uid    (card_uid),
    .card_valid  (card_valid),
    .new_card    (new_card),
    .card_removed(card_removed),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // Free-running clock and cycle index used to measure rc_start spacing.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for an rc_start pulse and return its cycle index.
  task automatic waitStart(output int s);
    s = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rc_start === 1'b1) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) checkOutput("start_seen", rc_start, 1);
  endtask

  // One reader transaction: dly>0 answers with uid in cycle start+dly,
  // dly==0 never answers. enable drops in cycle start+drop_at if drop_at>0.
  // Returns the event pulses seen in the cycle after EVAL.
  task automatic applyStimulus(input logic [31:0] uid, input int dly, input int drop_at,
                               output int s, output logic e_nc, output logic e_rm,
                               output logic e_to);
    int n;
    waitStart(s);
    n = (dly > 0) ? dly : TIMEOUT;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("start_one_cycle", rc_start, 0);
      if (k == drop_at) enable = 1'b0;
    end
    if (dly > 0) begin
      rc_done = 1'b1;
      rc_uid  = uid;
    end
    @(negedge clk);
    rc_done = 1'b0;
    rc_uid  = 32'h0;
    checkOutput("eval_busy", busy, 1);
    checkOutput("pulse_before_eval", {new_card, card_removed, timeout_err}, 0);
    @(negedge clk);
    e_nc = new_card;
    e_rm = card_removed;
    e_to = timeout_err;
    @(negedge clk);
    checkOutput("pulse_width", {new_card, card_removed, timeout_err}, 0);
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    rc_done = 1'b0;
    rc_uid  = 32'h0;
    seen    = 1'b0;

    // Held reset: nothing may move.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rc_start !== 1'b0) seen = 1'b1;
    end
    checkOutput("reset_no_start", seen, 0);
    checkOutput("reset_card_uid", card_uid, 0);
    checkOutput("reset_flags", {card_valid, new_card, card_removed, timeout_err, busy}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    // rc_done outside WAIT_DONE is ignored.
    rc_done = 1'b1;
    rc_uid  = 32'hABCDEF12;
    @(negedge clk);
    rc_done = 1'b0;
    rc_uid  = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("stray_done_valid", card_valid, 0);
    checkOutput("stray_done_uid", card_uid, 0);

    // First card appears.
    enable = 1'b1;
    applyStimulus(32'hABCDEF12, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p1_new_card", nc, 1);
    checkOutput("p1_removed", rm, 0);
    checkOutput("p1_timeout", to, 0);
    checkOutput("p1_card_uid", card_uid, 32'hABCDEF12);
    checkOutput("p1_card_valid", card_valid, 1);
    s_prev = s_cur;

    // Same card again: no event, fixed spacing.
    applyStimulus(32'hABCDEF12, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p2_new_card", nc, 0);
    checkOutput("p2_spacing", s_cur - s_prev, SPACING);
    s_prev = s_cur;
    applyStimulus(32'hABCDEF12, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p3_new_card", nc, 0);
    checkOutput("p3_spacing", s_cur - s_prev, SPACING);

    // UID change.
    applyStimulus(32'h11223344, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p4_new_card", nc, 1);
    checkOutput("p4_removed", rm, 0);
    checkOutput("p4_card_uid", card_uid, 32'h11223344);

    // Two misses then a hit: no removal, miss count restarts.
    applyStimulus(32'h0, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p5_removed", rm, 0);
    checkOutput("p5_card_uid", card_uid, 32'h11223344);
    applyStimulus(32'h0, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p6_removed", rm, 0);
    checkOutput("p6_card_valid", card_valid, 1);
    applyStimulus(32'hABCDEF12, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p7_new_card", nc, 1);
    checkOutput("p7_card_uid", card_uid, 32'hABCDEF12);

    // Three misses: removal on the third.
    applyStimulus(32'h0, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p8_removed", rm, 0);
    applyStimulus(32'h0, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p9_removed", rm, 0);
    applyStimulus(32'h0, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p10_removed", rm, 1);
    checkOutput("p10_new_card", nc, 0);
    checkOutput("p10_card_valid", card_valid, 0);
    checkOutput("p10_card_uid", card_uid, 0);
    applyStimulus(32'h0, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p11_removed", rm, 0);

    // Reader hangs: timeout pulse, next start after TIMEOUT+1+POLL_PERIOD+1.
    applyStimulus(32'h0, 0, 0, s_cur, nc, rm, to);
    checkOutput("p12_timeout", to, 1);
    checkOutput("p12_removed", rm, 0);
    checkOutput("p12_new_card", nc, 0);
    s_prev = s_cur;

    // Done on the exact expiry cycle wins over the timeout.
    applyStimulus(32'hDEADBEEF, TIMEOUT, 0, s_cur, nc, rm, to);
    checkOutput("p13_spacing", s_cur - s_prev, TMO_SPACING);
    checkOutput("p13_timeout", to, 0);
    checkOutput("p13_new_card", nc, 1);
    checkOutput("p13_card_uid", card_uid, 32'hDEADBEEF);

    // Timeout with a card present: one miss, no removal.
    applyStimulus(32'h0, 0, 0, s_cur, nc, rm, to);
    checkOutput("p14_timeout", to, 1);
    checkOutput("p14_removed", rm, 0);
    checkOutput("p14_card_valid", card_valid, 1);

    // Disable mid-transaction: completes, then parks in IDLE.
    applyStimulus(32'hDEADBEEF, DONE_DLY, 5, s_cur, nc, rm, to);
    checkOutput("p15_new_card", nc, 0);
    checkOutput("p15_idle_busy", busy, 0);
    checkOutput("p15_card_valid", card_valid, 1);
    checkOutput("p15_card_uid", card_uid, 32'hDEADBEEF);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rc_start !== 1'b0) seen = 1'b1;
    end
    checkOutput("disabled_no_start", seen, 0);

    // Reset during WAIT_DONE clears everything immediately.
    enable = 1'b1;
    waitStart(s_cur);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_card_uid", card_uid, 0);
    checkOutput("rst_flags", {card_valid, new_card, card_removed, timeout_err, busy, rc_start}, 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_idle_busy", busy, 0);

    // Polling restarts cleanly from IDLE after reset.
    enable = 1'b1;
    applyStimulus(32'h00000055, DONE_DLY, 0, s_cur, nc, rm, to);
    checkOutput("p16_new_card", nc, 1);
    checkOutput("p16_card_uid", card_uid, 32'h00000055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
